// File: rtl/fetch_buffer.sv
// In-order fetch buffer between the PC fetch unit and decode: issues imem requests,
// collects in-order responses and hands instructions to decode; flush kills in-flight work.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_pc,
    input  logic            io_flush,
    output logic            io_imem_req_valid,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_req_ready,
    input  logic            io_imem_rsp_valid,
    input  logic [XLEN-1:0] io_imem_rsp_data,
    output logic            io_dec_valid,
    output logic [XLEN-1:0] io_dec_inst,
    output logic [XLEN-1:0] io_dec_pc,
    input  logic            io_dec_ready,
    output logic            io_stall_en
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ZERO_P  = {PW{1'b0}};
    localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);

    logic [XLEN-1:0]  pc_r     [DEPTH];
    logic [XLEN-1:0]  inst_r   [DEPTH];
    logic [DEPTH-1:0] filled_r;
    logic [PW-1:0]    rptr_r;
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    fptr_r;
    logic [PW-1:0]    drop_r;

    logic [PW-1:0]    count_s;
    logic [PW-1:0]    unfilled_s;
    logic [PW:0]      occ_s;
    logic             req_valid_s;
    logic             fire_s;
    logic             rsp_drop_s;
    logic             rsp_fill_s;
    logic             dec_valid_s;
    logic             deq_s;
    logic [PW:0]      flush_drop_s;

    // Occupancy, handshake qualifiers and post-flush drop count.
    always_comb begin
        count_s     = wptr_r - rptr_r;
        unfilled_s  = wptr_r - fptr_r;
        occ_s       = {1'b0, count_s} + {1'b0, drop_r};
        req_valid_s = !reset && !io_flush && (occ_s < DEPTH_W);
        fire_s      = req_valid_s && io_imem_req_ready;
        // Killed responses are still owed by memory and drain before any live fill.
        rsp_drop_s  = io_imem_rsp_valid && (drop_r != ZERO_P);
        rsp_fill_s  = io_imem_rsp_valid && (drop_r == ZERO_P) && (unfilled_s != ZERO_P);
        dec_valid_s = (count_s != ZERO_P) && filled_r[rptr_r[AW-1:0]];
        deq_s       = dec_valid_s && io_dec_ready;
        // A live fill in the flush cycle consumes its own response, so it is not owed later.
        flush_drop_s = {1'b0, drop_r} + {1'b0, unfilled_s}
                     - {{PW{1'b0}}, rsp_drop_s} - {{PW{1'b0}}, rsp_fill_s};
    end

    assign io_imem_req_valid = req_valid_s;
    assign io_imem_req_addr  = io_pc;
    assign io_stall_en       = !fire_s;
    assign io_dec_valid      = dec_valid_s;
    assign io_dec_inst       = inst_r[rptr_r[AW-1:0]];
    assign io_dec_pc         = pc_r[rptr_r[AW-1:0]];

    // Entry storage, pointers and drop counter; flush outranks every other update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]   <= {XLEN{1'b0}};
                inst_r[i] <= {XLEN{1'b0}};
            end
            filled_r <= {DEPTH{1'b0}};
            rptr_r   <= ZERO_P;
            wptr_r   <= ZERO_P;
            fptr_r   <= ZERO_P;
            drop_r   <= ZERO_P;
        end else if (io_flush) begin
            filled_r <= {DEPTH{1'b0}};
            rptr_r   <= ZERO_P;
            wptr_r   <= ZERO_P;
            fptr_r   <= ZERO_P;
            drop_r   <= flush_drop_s[PW-1:0];
        end else begin
            if (fire_s) begin
                pc_r[wptr_r[AW-1:0]]     <= io_pc;
                filled_r[wptr_r[AW-1:0]] <= 1'b0;
                wptr_r                   <= wptr_r + ONE_P;
            end
            if (rsp_drop_s) begin
                drop_r <= drop_r - ONE_P;
            end else if (rsp_fill_s) begin
                inst_r[fptr_r[AW-1:0]]   <= io_imem_rsp_data;
                filled_r[fptr_r[AW-1:0]] <= 1'b1;
                fptr_r                   <= fptr_r + ONE_P;
            end
            if (deq_s) begin
                filled_r[rptr_r[AW-1:0]] <= 1'b0;
                rptr_r                   <= rptr_r + ONE_P;
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a 1-cycle in-order memory model plus a decode scoreboard.
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [XLEN-1:0] io_pc;
    logic            io_flush;
    logic            io_imem_req_valid;
    logic [XLEN-1:0] io_imem_req_addr;
    logic            io_imem_req_ready;
    logic            io_imem_rsp_valid;
    logic [XLEN-1:0] io_imem_rsp_data;
    logic            io_dec_valid;
    logic [XLEN-1:0] io_dec_inst;
    logic [XLEN-1:0] io_dec_pc;
    logic            io_dec_ready;
    logic            io_stall_en;

    always #5 clock = ~clock;

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_pc             (io_pc),
        .io_flush          (io_flush),
        .io_imem_req_valid (io_imem_req_valid),
        .io_imem_req_addr  (io_imem_req_addr),
        .io_imem_req_ready (io_imem_req_ready),
        .io_imem_rsp_valid (io_imem_rsp_valid),
        .io_imem_rsp_data  (io_imem_rsp_data),
        .io_dec_valid      (io_dec_valid),
        .io_dec_inst       (io_dec_inst),
        .io_dec_pc         (io_dec_pc),
        .io_dec_ready      (io_dec_ready),
        .io_stall_en       (io_stall_en)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          mem_en;
    logic        s_fire, s_dec_valid, s_stall, s_req_valid;
    logic [31:0] s_dec_pc, s_req_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc ^ 32'hDEAD_0000) + 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score at negedge, then advance fetch PC and memory after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        s_fire      = io_imem_req_valid && io_imem_req_ready;
        s_dec_valid = io_dec_valid;
        s_dec_pc    = io_dec_pc;
        s_stall     = io_stall_en;
        s_req_valid = io_imem_req_valid;
        s_req_addr  = io_imem_req_addr;
        if (io_dec_valid && io_dec_ready && !io_flush) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_dec", {31'd0, io_dec_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_dec_pc", io_dec_pc, e.pc);
                chk("sb_dec_inst", io_dec_inst, e.inst);
            end
        end
        if (io_flush) exp_q.delete();
        if (s_fire) begin
            exp_q.push_back('{io_pc, inst_of(io_pc)});
            mem_q.push_back(io_imem_req_addr);
        end
        @(posedge clock);
        #1;
        if (s_fire) io_pc = io_pc + 32'd4;
        if (mem_en && mem_q.size() > 0) begin
            io_imem_rsp_valid = 1'b1;
            io_imem_rsp_data  = inst_of(mem_q.pop_front());
        end else begin
            io_imem_rsp_valid = 1'b0;
            io_imem_rsp_data  = 32'd0;
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset = 1'b1;
        io_flush = 1'b0;
        io_imem_rsp_valid = 1'b0;
        io_imem_rsp_data = 32'd0;
        exp_q.delete();
        mem_q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        io_pc = start_pc;
    endtask

    initial begin
        reset = 1'b1;
        io_pc = 32'd0;
        io_flush = 1'b0;
        io_imem_req_ready = 1'b0;
        io_imem_rsp_valid = 1'b0;
        io_imem_rsp_data = 32'd0;
        io_dec_ready = 1'b0;
        mem_en = 1'b0;
        #3;
        chk("rst_req_valid", {31'd0, io_imem_req_valid}, 32'd0);
        chk("rst_dec_valid", {31'd0, io_dec_valid}, 32'd0);
        chk("rst_dec_inst", io_dec_inst, 32'd0);
        chk("rst_dec_pc", io_dec_pc, 32'd0);
        chk("rst_stall", {31'd0, io_stall_en}, 32'd1);

        // Steady stream, then a 3-cycle memory stall.
        do_reset(32'd0);
        io_imem_req_ready = 1'b1; io_dec_ready = 1'b1; mem_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_stall", {31'd0, s_stall}, 32'd0);
            if (i == 0) chk("t1_first_fire", {31'd0, s_fire}, 32'd1);
            if (i < 2) chk("t1_no_early_dec", {31'd0, s_dec_valid}, 32'd0);
            else begin
                chk("t1_dec_valid", {31'd0, s_dec_valid}, 32'd1);
                chk("t1_dec_pc", s_dec_pc, 32'(4 * (i - 2)));
            end
        end
        io_imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall", {31'd0, s_stall}, 32'd1);
            chk("t3_addr_held", s_req_addr, 32'd32);
            if (i == 2) chk("t3_no_alloc", {31'd0, s_dec_valid}, 32'd0);
        end

        // Decode backpressure fills the buffer.
        do_reset(32'd0);
        io_imem_req_ready = 1'b1; io_dec_ready = 1'b0; mem_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < DEPTH) chk("t2_fire", {31'd0, s_fire}, 32'd1);
            else begin
                chk("t2_full_req_valid", {31'd0, s_req_valid}, 32'd0);
                chk("t2_full_stall", {31'd0, s_stall}, 32'd1);
            end
        end
        io_dec_ready = 1'b1; io_imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_drain_valid", {31'd0, s_dec_valid}, 32'd1);
            chk("t2_drain_pc", s_dec_pc, 32'(4 * i));
        end
        tick();
        chk("t2_empty", {31'd0, s_dec_valid}, 32'd0);

        // Fire, response and dequeue together with two entries held.
        do_reset(32'd0);
        io_imem_req_ready = 1'b1; io_dec_ready = 1'b0; mem_en = 1'b1;
        tick(); chk("t5_fire0", {31'd0, s_fire}, 32'd1);
        tick(); chk("t5_fire1", {31'd0, s_fire}, 32'd1);
        io_dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_fire", {31'd0, s_fire}, 32'd1);
            chk("t5_dec_valid", {31'd0, s_dec_valid}, 32'd1);
            chk("t5_dec_pc", s_dec_pc, 32'(4 * i));
        end
        io_imem_req_ready = 1'b0;
        tick(); chk("t5_tail0", s_dec_pc, 32'd24);
        tick(); chk("t5_tail1", s_dec_pc, 32'd28);
        tick(); chk("t5_count_two", {31'd0, s_dec_valid}, 32'd0);

        // Flush with two unfilled entries and no response in the flush cycle.
        do_reset(32'd0);
        io_imem_req_ready = 1'b1; io_dec_ready = 1'b1; mem_en = 1'b0;
        tick(); tick();
        io_flush = 1'b1; mem_en = 1'b1;
        tick();
        chk("t4a_flush_req_valid", {31'd0, s_req_valid}, 32'd0);
        chk("t4a_flush_stall", {31'd0, s_stall}, 32'd1);
        io_flush = 1'b0; io_pc = 32'h100;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 3) chk("t4a_dropped", {31'd0, s_dec_valid}, 32'd0);
            if (i == 3) chk("t4a_first_pc", s_dec_pc, 32'h100);
        end

        // Flush whose cycle carries a response: that response must not be owed again.
        do_reset(32'd0);
        io_imem_req_ready = 1'b1; io_dec_ready = 1'b1; mem_en = 1'b0;
        tick();
        mem_en = 1'b1;
        tick();
        io_flush = 1'b1; mem_en = 1'b0;
        tick();
        io_flush = 1'b0; io_pc = 32'h200; mem_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 3) chk("t4b_dropped", {31'd0, s_dec_valid}, 32'd0);
            if (i == 3) chk("t4b_first_pc", s_dec_pc, 32'h200);
        end

        // Asynchronous reset between edges with three entries buffered.
        do_reset(32'd0);
        io_imem_req_ready = 1'b1; io_dec_ready = 1'b0; mem_en = 1'b1;
        tick(); tick(); tick();
        io_imem_req_ready = 1'b0;
        tick(); tick();
        chk("t6_pre_valid", {31'd0, io_dec_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req_valid", {31'd0, io_imem_req_valid}, 32'd0);
        chk("t6_dec_valid", {31'd0, io_dec_valid}, 32'd0);
        chk("t6_dec_inst", io_dec_inst, 32'd0);
        chk("t6_dec_pc", io_dec_pc, 32'd0);
        chk("t6_stall", {31'd0, io_stall_en}, 32'd1);
        exp_q.delete(); mem_q.delete();
        io_imem_rsp_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0; io_pc = 32'h300; io_dec_ready = 1'b1;
        tick(); chk("t6_idle0", {31'd0, s_dec_valid}, 32'd0);
        tick(); chk("t6_idle1", {31'd0, s_dec_valid}, 32'd0);
        io_imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) chk("t6_wait", {31'd0, s_dec_valid}, 32'd0);
            else chk("t6_new_pc", s_dec_pc, 32'h300);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
